// File: rtl/gpio_bank_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : gpio_bank_pkg
//  Description : Shared constants for the GPIO bank: bus width, register
//                indices and the length of the post-reset arming window.
//  Revision    : 1.0
// ============================================================================
package gpio_bank_pkg;

  localparam int BUS_W = 32;

  // Register indices on bus_addr
  typedef enum logic [2:0] {
    ADDR_OUT      = 3'd0,
    ADDR_OE       = 3'd1,
    ADDR_IN       = 3'd2,
    ADDR_IRQ_EN   = 3'd3,
    ADDR_IRQ_POL  = 3'd4,
    ADDR_IRQ_STAT = 3'd5,
    ADDR_OUT_SET  = 3'd6,
    ADDR_OUT_CLR  = 3'd7
  } reg_addr_e;

  // Arming lasts while the arming counter is below this value (3 cycles)
  localparam logic [1:0] ARM_LAST = 2'd3;

endpackage : gpio_bank_pkg
`default_nettype wire

// File: rtl/gpio_in_filter.sv
`default_nettype none
// ============================================================================
//  Module      : gpio_in_filter
//  Description : One pad input: 2-flop synchroniser followed by a stable-count
//                debounce. While arming is high the filtered value tracks the
//                synchronised value directly.
//  Revision    : 1.0
// ============================================================================
module gpio_in_filter #(
  parameter int DEB_CYCLES = 4
) (
  input  logic ppm_clk,
  input  logic ppm_rst,
  input  logic arming,
  input  logic pin_in,
  output logic filt
);

  logic sync1_q, sync1_d;
  logic sync2_q, sync2_d;

  // Synchroniser next-state
  always_comb begin
    sync1_d = pin_in;
    sync2_d = sync1_q;
  end

  // Synchroniser flops
  always_ff @(posedge ppm_clk) begin
    if (ppm_rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
    end
  end

  generate
    if (DEB_CYCLES == 0) begin : g_bypass
      // No debounce: the filtered value is the synchronised value
      logic unused_arming;
      assign unused_arming = arming;
      assign filt = sync2_q;
    end else begin : g_debounce
      localparam logic [7:0] DEB_LAST = 8'(DEB_CYCLES - 1);

      logic [7:0] cnt_q, cnt_d;
      logic       filt_q, filt_d;

      // Count consecutive cycles where synced differs from filtered
      always_comb begin
        filt_d = filt_q;
        cnt_d  = cnt_q;
        if (arming) begin
          filt_d = sync2_q;
          cnt_d  = '0;
        end else if (sync2_q == filt_q) begin
          cnt_d  = '0;
        end else if (cnt_q == DEB_LAST) begin
          filt_d = sync2_q;
          cnt_d  = '0;
        end else begin
          cnt_d  = cnt_q + 8'd1;
        end
      end

      // Debounce state flops
      always_ff @(posedge ppm_clk) begin
        if (ppm_rst) begin
          filt_q <= 1'b0;
          cnt_q  <= '0;
        end else begin
          filt_q <= filt_d;
          cnt_q  <= cnt_d;
        end
      end

      assign filt = filt_q;
    end
  endgenerate

endmodule : gpio_in_filter
`default_nettype wire

// File: rtl/gpio_bank_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : gpio_bank_ctrl
//  Description : GPIO bank with output/enable registers, filtered inputs,
//                edge-triggered interrupt status (W1C) and a 1-cycle-latency
//                register read port.
//  Revision    : 1.0
// ============================================================================
module gpio_bank_ctrl
  import gpio_bank_pkg::*;
#(
  parameter int NUM_PINS   = 16,
  parameter int DEB_CYCLES = 4
) (
  input  logic                ppm_clk,
  input  logic                ppm_rst,
  input  logic                bus_wr,
  input  logic                bus_rd,
  input  logic [2:0]          bus_addr,
  input  logic [BUS_W-1:0]    bus_wdata,
  output logic [BUS_W-1:0]    bus_rdata,
  output logic                bus_rvalid,
  input  logic [NUM_PINS-1:0] gpio_in,
  output logic [NUM_PINS-1:0] gpio_out,
  output logic [NUM_PINS-1:0] gpio_oe_n,
  output logic                irq
);

  logic [NUM_PINS-1:0] out_q,  out_d;
  logic [NUM_PINS-1:0] oe_q,   oe_d;
  logic [NUM_PINS-1:0] en_q,   en_d;
  logic [NUM_PINS-1:0] pol_q,  pol_d;
  logic [NUM_PINS-1:0] stat_q, stat_d;
  logic [NUM_PINS-1:0] filt_prev_q, filt_prev_d;
  logic [NUM_PINS-1:0] filt;
  logic [NUM_PINS-1:0] ev;
  logic [NUM_PINS-1:0] stat_clr;
  logic [NUM_PINS-1:0] wdata;
  logic [BUS_W-1:0]    rdata_q, rdata_d;
  logic                rvalid_q, rvalid_d;
  logic                irq_q, irq_d;
  logic [1:0]          arm_cnt_q, arm_cnt_d;
  logic                arming;
  logic                arming_prev_q, arming_prev_d;

  // Upper write-data bits beyond NUM_PINS have no destination
  logic unused_wdata;
  assign unused_wdata = ^bus_wdata;

  assign wdata = bus_wdata[NUM_PINS-1:0];

  // Arming window: counts the first cycles after reset release
  always_comb begin
    arming        = (arm_cnt_q != ARM_LAST);
    arm_cnt_d     = arming ? arm_cnt_q + 2'd1 : arm_cnt_q;
    arming_prev_d = arming;
  end

  // Per-pin synchroniser and debounce
  generate
    for (genvar i = 0; i < NUM_PINS; i++) begin : g_pin
      gpio_in_filter #(
        .DEB_CYCLES (DEB_CYCLES)
      ) u_filter (
        .ppm_clk (ppm_clk),
        .ppm_rst (ppm_rst),
        .arming  (arming),
        .pin_in  (gpio_in[i]),
        .filt    (filt[i])
      );
    end
  endgenerate

  // Edge detection on filtered inputs; the cycle that closes the arming
  // window still sees the arming load as a transition, so it is masked too
  always_comb begin
    filt_prev_d = filt;
    if (arming_prev_q) begin
      ev = '0;
    end else begin
      ev = (filt & ~filt_prev_q & pol_q) | (~filt & filt_prev_q & ~pol_q);
    end
  end

  // Register writes and interrupt status update (hardware set beats W1C)
  always_comb begin
    out_d    = out_q;
    oe_d     = oe_q;
    en_d     = en_q;
    pol_d    = pol_q;
    stat_clr = '0;
    if (bus_wr) begin
      case (bus_addr)
        ADDR_OUT:      out_d    = wdata;
        ADDR_OE:       oe_d     = wdata;
        ADDR_IRQ_EN:   en_d     = wdata;
        ADDR_IRQ_POL:  pol_d    = wdata;
        ADDR_IRQ_STAT: stat_clr = wdata;
        ADDR_OUT_SET:  out_d    = out_q | wdata;
        ADDR_OUT_CLR:  out_d    = out_q & ~wdata;
        default:       ;
      endcase
    end
    stat_d = (stat_q & ~stat_clr) | ev;
    irq_d  = |(stat_q & en_q);
  end

  // Read mux: samples pre-write register state, zero when not reading
  always_comb begin
    rdata_d  = '0;
    rvalid_d = bus_rd;
    if (bus_rd) begin
      case (bus_addr)
        ADDR_OUT:      rdata_d[NUM_PINS-1:0] = out_q;
        ADDR_OE:       rdata_d[NUM_PINS-1:0] = oe_q;
        ADDR_IN:       rdata_d[NUM_PINS-1:0] = filt;
        ADDR_IRQ_EN:   rdata_d[NUM_PINS-1:0] = en_q;
        ADDR_IRQ_POL:  rdata_d[NUM_PINS-1:0] = pol_q;
        ADDR_IRQ_STAT: rdata_d[NUM_PINS-1:0] = stat_q;
        default:       rdata_d = '0;
      endcase
    end
  end

  // State registers
  always_ff @(posedge ppm_clk) begin
    if (ppm_rst) begin
      out_q         <= '0;
      oe_q          <= '0;
      en_q          <= '0;
      pol_q         <= '0;
      stat_q        <= '0;
      filt_prev_q   <= '0;
      rdata_q       <= '0;
      rvalid_q      <= 1'b0;
      irq_q         <= 1'b0;
      arm_cnt_q     <= '0;
      arming_prev_q <= 1'b1;
    end else begin
      out_q         <= out_d;
      oe_q          <= oe_d;
      en_q          <= en_d;
      pol_q         <= pol_d;
      stat_q        <= stat_d;
      filt_prev_q   <= filt_prev_d;
      rdata_q       <= rdata_d;
      rvalid_q      <= rvalid_d;
      irq_q         <= irq_d;
      arm_cnt_q     <= arm_cnt_d;
      arming_prev_q <= arming_prev_d;
    end
  end

  assign gpio_out   = out_q;
  assign gpio_oe_n  = ~oe_q;
  assign bus_rdata  = rdata_q;
  assign bus_rvalid = rvalid_q;
  assign irq        = irq_q;

endmodule : gpio_bank_ctrl
`default_nettype wire

// File: tb/tb_gpio_bank_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_gpio_bank_ctrl
//  Description : Directed self-checking bench for gpio_bank_ctrl (16 pins,
//                DEB_CYCLES = 4) plus a 5-pin instance for width masking.
//  Revision    : 1.0
// ============================================================================
module tb_gpio_bank_ctrl;
  import gpio_bank_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        bus_wr, bus_rd;
  logic [2:0]  bus_addr;
  logic [31:0] bus_wdata, bus_rdata;
  logic        bus_rvalid;
  logic [15:0] gpio_in, gpio_out, gpio_oe_n;
  logic        irq;

  logic        wr5, rd5;
  logic [2:0]  addr5;
  logic [31:0] wdata5, rdata5;
  logic        rvalid5;
  logic [4:0]  gin5, gout5, goe5_n;
  logic        irq5;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  gpio_bank_ctrl #(.NUM_PINS(16), .DEB_CYCLES(4)) dut (
    .ppm_clk(clk), .ppm_rst(rst), .bus_wr(bus_wr), .bus_rd(bus_rd),
    .bus_addr(bus_addr), .bus_wdata(bus_wdata), .bus_rdata(bus_rdata),
    .bus_rvalid(bus_rvalid), .gpio_in(gpio_in), .gpio_out(gpio_out),
    .gpio_oe_n(gpio_oe_n), .irq(irq)
  );

  gpio_bank_ctrl #(.NUM_PINS(5), .DEB_CYCLES(4)) dut5 (
    .ppm_clk(clk), .ppm_rst(rst), .bus_wr(wr5), .bus_rd(rd5),
    .bus_addr(addr5), .bus_wdata(wdata5), .bus_rdata(rdata5),
    .bus_rvalid(rvalid5), .gpio_in(gin5), .gpio_out(gout5),
    .gpio_oe_n(goe5_n), .irq(irq5)
  );

  // All tasks start and end on a falling edge
  task automatic bus_write(input logic [2:0] a, input logic [31:0] d);
    bus_wr = 1'b1; bus_addr = a; bus_wdata = d;
    @(negedge clk);
    bus_wr = 1'b0; bus_wdata = '0;
  endtask

  task automatic bus_read(input logic [2:0] a, output logic [31:0] d, output logic v);
    bus_rd = 1'b1; bus_addr = a;
    @(negedge clk);
    bus_rd = 1'b0;
    d = bus_rdata; v = bus_rvalid;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if (gpio_oe_n !== 16'hFFFF) begin errors++; $display("FAIL reset_oe_n: got %h expected ffff", gpio_oe_n); end
    checks++;
    if (gpio_out !== 16'h0000) begin errors++; $display("FAIL reset_out: got %h expected 0000", gpio_out); end
    checks++;
    if (irq !== 1'b0) begin errors++; $display("FAIL reset_irq: got %b expected 0", irq); end
    checks++;
    if (bus_rvalid !== 1'b0 || bus_rdata !== 32'h0) begin errors++; $display("FAIL reset_bus: got rvalid %b rdata %h expected 0/0", bus_rvalid, bus_rdata); end
    // Read issued in the last reset cycle must be dropped
    bus_rd = 1'b1; bus_addr = ADDR_OUT;
    @(negedge clk);
    bus_rd = 1'b0; rst = 1'b0;
    checks++;
    if (bus_rvalid !== 1'b0) begin errors++; $display("FAIL reset_read_abort: got rvalid %b expected 0", bus_rvalid); end
    @(negedge clk);
    checks++;
    if (bus_rvalid !== 1'b0) begin errors++; $display("FAIL reset_read_abort2: got rvalid %b expected 0", bus_rvalid); end
    repeat (5) @(negedge clk);
  endtask

  task automatic test_basic();
    logic [31:0] d; logic v;
    bus_write(ADDR_OE, 32'h0000_0003);
    bus_write(ADDR_OUT, 32'h0000_0001);
    checks++;
    if (gpio_oe_n !== 16'hFFFC) begin errors++; $display("FAIL basic_oe_n: got %h expected fffc", gpio_oe_n); end
    checks++;
    if (gpio_out !== 16'h0001) begin errors++; $display("FAIL basic_out: got %h expected 0001", gpio_out); end
    bus_read(ADDR_OUT, d, v);
    checks++;
    if (v !== 1'b1 || d !== 32'h0000_0001) begin errors++; $display("FAIL basic_read: got rvalid %b rdata %h expected 1/00000001", v, d); end
    @(negedge clk);
    checks++;
    if (bus_rvalid !== 1'b0 || bus_rdata !== 32'h0) begin errors++; $display("FAIL basic_rvalid_pulse: got rvalid %b rdata %h expected 0/0", bus_rvalid, bus_rdata); end
  endtask

  task automatic test_set_clr();
    logic [31:0] d; logic v;
    bus_write(ADDR_OUT, 32'h0000_00F0);
    bus_write(ADDR_OUT_SET, 32'h0000_000F);
    bus_write(ADDR_OUT_CLR, 32'h0000_0030);
    bus_read(ADDR_OUT, d, v);
    checks++;
    if (d !== 32'h0000_00CF) begin errors++; $display("FAIL setclr_out: got %h expected 000000cf", d); end
    checks++;
    if (gpio_out !== 16'h00CF) begin errors++; $display("FAIL setclr_pins: got %h expected 00cf", gpio_out); end
    bus_read(ADDR_OUT_SET, d, v);
    checks++;
    if (d !== 32'h0 || v !== 1'b1) begin errors++; $display("FAIL read_set_reg: got %h/%b expected 0/1", d, v); end
    bus_read(ADDR_OUT_CLR, d, v);
    checks++;
    if (d !== 32'h0) begin errors++; $display("FAIL read_clr_reg: got %h expected 0", d); end
    // Simultaneous write and read returns the pre-write value
    bus_wr = 1'b1; bus_rd = 1'b1; bus_addr = ADDR_OUT; bus_wdata = 32'h0000_1234;
    @(negedge clk);
    bus_wr = 1'b0; bus_rd = 1'b0;
    checks++;
    if (bus_rdata !== 32'h0000_00CF || gpio_out !== 16'h1234) begin errors++; $display("FAIL wr_rd_same: got rdata %h out %h expected 000000cf/1234", bus_rdata, gpio_out); end
  endtask

  task automatic test_debounce();
    logic [31:0] d; logic v;
    bus_write(ADDR_IRQ_POL, 32'h0000_0004);
    // 3-cycle glitch on pin 2 is rejected
    gpio_in[2] = 1'b1;
    repeat (3) @(negedge clk);
    gpio_in[2] = 1'b0;
    repeat (10) @(negedge clk);
    bus_read(ADDR_IN, d, v);
    checks++;
    if (d !== 32'h0) begin errors++; $display("FAIL glitch_in: got %h expected 0", d); end
    bus_read(ADDR_IRQ_STAT, d, v);
    checks++;
    if (d !== 32'h0) begin errors++; $display("FAIL glitch_stat: got %h expected 0", d); end
    // Held high: filtered value flips on the 6th edge after the change
    gpio_in[2] = 1'b1;
    repeat (5) @(negedge clk);
    bus_read(ADDR_IN, d, v);
    checks++;
    if (d !== 32'h0) begin errors++; $display("FAIL deb_early: got %h expected 0", d); end
    bus_read(ADDR_IN, d, v);
    checks++;
    if (d !== 32'h0000_0004) begin errors++; $display("FAIL deb_in: got %h expected 00000004", d); end
    bus_read(ADDR_IRQ_STAT, d, v);
    checks++;
    if (d !== 32'h0000_0004) begin errors++; $display("FAIL deb_stat: got %h expected 00000004", d); end
  endtask

  task automatic test_irq();
    logic [31:0] d; logic v;
    bus_write(ADDR_IRQ_EN, 32'h0000_0004);
    checks++;
    if (irq !== 1'b0) begin errors++; $display("FAIL irq_latency: got %b expected 0", irq); end
    @(negedge clk);
    checks++;
    if (irq !== 1'b1) begin errors++; $display("FAIL irq_assert: got %b expected 1", irq); end
    // Drop pin 2 (falling edge, ignored for rising polarity)
    gpio_in[2] = 1'b0;
    repeat (10) @(negedge clk);
    // New rising edge; its status set coincides with a W1C
    gpio_in[2] = 1'b1;
    repeat (6) @(negedge clk);
    bus_write(ADDR_IRQ_STAT, 32'h0000_0004);
    bus_read(ADDR_IRQ_STAT, d, v);
    checks++;
    if (d !== 32'h0000_0004) begin errors++; $display("FAIL set_beats_w1c: got %h expected 00000004", d); end
    checks++;
    if (irq !== 1'b1) begin errors++; $display("FAIL irq_hold: got %b expected 1", irq); end
    bus_write(ADDR_IRQ_STAT, 32'h0000_0004);
    checks++;
    if (irq !== 1'b1) begin errors++; $display("FAIL irq_clr_latency: got %b expected 1", irq); end
    @(negedge clk);
    checks++;
    if (irq !== 1'b0) begin errors++; $display("FAIL irq_clear: got %b expected 0", irq); end
  endtask

  task automatic test_arming();
    logic [31:0] d; logic v;
    gpio_in = 16'hFFFF;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    checks++;
    if (gpio_oe_n !== 16'hFFFF || irq !== 1'b0) begin errors++; $display("FAIL rearm_reset: got oe_n %h irq %b expected ffff/0", gpio_oe_n, irq); end
    repeat (3) @(negedge clk);
    bus_read(ADDR_IN, d, v);
    checks++;
    if (d !== 32'h0000_FFFF) begin errors++; $display("FAIL arm_in: got %h expected 0000ffff", d); end
    repeat (10) @(negedge clk);
    bus_read(ADDR_IRQ_STAT, d, v);
    checks++;
    if (d !== 32'h0) begin errors++; $display("FAIL arm_stat: got %h expected 0", d); end
  endtask

  task automatic test_narrow();
    wr5 = 1'b1; addr5 = ADDR_OE; wdata5 = 32'hFFFF_FFFF;
    @(negedge clk);
    wr5 = 1'b0;
    checks++;
    if (goe5_n !== 5'b00000) begin errors++; $display("FAIL narrow_oe_n: got %b expected 00000", goe5_n); end
    rd5 = 1'b1; addr5 = ADDR_OE;
    @(negedge clk);
    rd5 = 1'b0;
    checks++;
    if (rdata5 !== 32'h0000_001F || rvalid5 !== 1'b1) begin errors++; $display("FAIL narrow_read: got %h/%b expected 0000001f/1", rdata5, rvalid5); end
  endtask

  initial begin
    rst = 1'b1; bus_wr = 1'b0; bus_rd = 1'b0; bus_addr = '0; bus_wdata = '0;
    gpio_in = '0;
    wr5 = 1'b0; rd5 = 1'b0; addr5 = '0; wdata5 = '0; gin5 = '0;
    @(negedge clk);
    test_reset();
    test_basic();
    test_set_clr();
    test_debounce();
    test_irq();
    test_arming();
    test_narrow();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

endmodule : tb_gpio_bank_ctrl
`default_nettype wire

// File: doc/gpio_bank_ctrl.md
GPIO_BANK_CTRL -- requirements
Module: gpio_bank_ctrl

Interface
REQ-001 Parameter NUM_PINS, default 16, number of GPIO pins, legal range 1..32.
REQ-002 Parameter DEB_CYCLES, default 4, debounce stable-cycle count; 0 = debounce bypassed; legal range 0..255.
REQ-003 ppm_clk  in  1  sole clock, all logic rising-edge.
REQ-004 ppm_rst  in  1  reset, synchronous, active-high.
REQ-005 bus_wr  in  1  register write strobe, one-cycle pulse per access.
REQ-006 bus_rd  in  1  register read strobe, one-cycle pulse per access.
REQ-007 bus_addr  in  3  register index.
REQ-008 bus_wdata  in  32  write data.
REQ-009 bus_rdata  out  32  read data.
REQ-010 bus_rvalid  out  1  read data valid, one-cycle pulse.
REQ-011 gpio_in  in  NUM_PINS  asynchronous pad inputs.
REQ-012 gpio_out  out  NUM_PINS  pad output values.
REQ-013 gpio_oe_n  out  NUM_PINS  pad output enables, active-low.
REQ-014 irq  out  1  level interrupt, OR of (IRQ_STAT & IRQ_EN).

Function
REQ-015 Register map: 0 OUT (RW); 1 OE (RW, 1 = drive); 2 IN (RO, filtered inputs); 3 IRQ_EN (RW); 4 IRQ_POL (RW, 1 = rising, 0 = falling); 5 IRQ_STAT (W1C); 6 OUT_SET (WO, 1 sets OUT bits); 7 OUT_CLR (WO, 1 clears OUT bits).
REQ-016 Bits [31:NUM_PINS] ignored on write, read as 0; OUT_SET/OUT_CLR read as 0.
REQ-017 Write takes effect on the rising edge sampling bus_wr; gpio_out/gpio_oe_n reflect it the following cycle.
REQ-018 gpio_oe_n = ~OE, gpio_out = OUT, both registered, no combinational path from bus inputs.
REQ-019 Read latency exactly 1 cycle: bus_rdata and bus_rvalid valid the cycle after bus_rd; bus_rdata = 0 when bus_rvalid = 0.
REQ-020 bus_wr and bus_rd asserted together: write performed, read returns pre-write value.
REQ-021 gpio_in passes a 2-flop synchroniser per pin before any use.
REQ-022 Debounce per pin: counter resets whenever synced value equals filtered value; filtered value takes synced value after DEB_CYCLES consecutive differing cycles; DEB_CYCLES = 0 gives filtered = synced.
REQ-023 Edge event per pin: filtered transition matching IRQ_POL sets IRQ_STAT bit one cycle after filtered change, regardless of IRQ_EN.
REQ-024 Same-cycle hardware set and W1C on one IRQ_STAT bit: set wins, bit stays 1.
REQ-025 irq is registered, asserts one cycle after the IRQ_STAT/IRQ_EN condition becomes true.
REQ-026 Arming: for 3 cycles after reset release, filtered value loads directly from synced value and no edge events are generated.
REQ-027 Output pins read back via IN only through the pad loop; no internal feedback.

Reset
REQ-028 ppm_rst high on a ppm_clk edge: OUT, OE, IRQ_EN, IRQ_POL, IRQ_STAT, synchronisers, filtered values, debounce counters cleared to 0.
REQ-029 During and after reset: gpio_oe_n all 1 (pins tri-stated), gpio_out 0, irq 0, bus_rvalid 0, bus_rdata 0.
REQ-030 Reset mid-access aborts the access; no bus_rvalid pulse is produced for a read issued in the reset cycle.

Structure
REQ-031 Shared package gpio_bank_pkg holds register index constants (ADDR_OUT .. ADDR_OUT_CLR) and the 32-bit bus width constant.
REQ-032 One sub-module gpio_in_filter (per-pin synchroniser + debounce), instantiated NUM_PINS times via generate.

Verification
REQ-033 Reset then write OE = 0x0003, OUT = 0x0001 -> gpio_oe_n = 0xFFFC, gpio_out = 0x0001 next cycle; read OUT returns 0x00000001 with rvalid one cycle after bus_rd.
REQ-034 OUT = 0x00F0, write OUT_SET = 0x000F then OUT_CLR = 0x0030 -> OUT reads 0x00CF; reads of address 6/7 return 0.
REQ-035 DEB_CYCLES = 4, pin 2 glitch high 3 cycles -> IN bit 2 stays 0, no IRQ_STAT; held high 10 cycles -> IN = 0x0004 after 2+4 cycles, IRQ_STAT bit 2 set with IRQ_POL bit 2 = 1.
REQ-036 IRQ_EN = 0x0004, pending bit 2 -> irq = 1; W1C 0x0004 in same cycle as new rising edge on pin 2 -> bit stays 1, irq stays 1; later W1C alone -> irq 0 next cycle.
REQ-037 gpio_in = 0xFFFF held through reset release -> IN = 0xFFFF, IRQ_STAT = 0 (arming suppresses edges).
REQ-038 NUM_PINS = 5: write 0xFFFFFFFF to OE -> read returns 0x0000001F, gpio_oe_n = 5'b00000.
